axi_wr_slave_mem: RTL and testbench
===================================

// Module: axi_wr_slave_mem
// PURPOSE
//  AXI3/4 write-channel responder (slave end) with internal word-addressed memory.
//  Accepts AW, consumes W beats (FIXED/INCR/WRAP), applies byte strobes, returns B.
//  Sits as the DUT-side target opposite the master driver on the AXI interface.
//  Has a sideband debug read port so the bench can check memory contents.
// PARAMETERS
//  ADDR_W     32   awaddr width
//  DATA_W     32   wdata width; byte lanes = DATA_W/8
//  ID_W       4    awid/wid/bid width
//  MEM_WORDS  256  memory depth in DATA_W words; index = addr / (DATA_W/8)
// PORTS
//  clock      in   1         single clock, all logic on posedge
//  areset     in   1         reset, asynchronous, active-high
//  awid       in   ID_W      write address ID
//  awaddr     in   ADDR_W    burst start byte address
//  awlen      in   8         beats-1
//  awsize     in   3         log2 bytes per beat
//  awburst    in   2         00 FIXED, 01 INCR, 10 WRAP, 11 reserved
//  awvalid    in   1         AW valid
//  awready    out  1         AW ready
//  wid        in   ID_W      write data ID
//  wdata      in   DATA_W    write data
//  wstrb      in   DATA_W/8  byte enables
//  wlast      in   1         last beat flag from master
//  wvalid     in   1         W valid
//  wready     out  1         W ready
//  bid        out  ID_W      response ID (= captured awid)
//  bresp      out  2         00 OKAY, 10 SLVERR
//  bvalid     out  1         B valid
//  bready     in   1         B ready
//  dbg_addr   in   $clog2(MEM_WORDS)  debug word index
//  dbg_data   out  DATA_W    mem[dbg_addr], combinational
// BEHAVIOUR
//  Clock: one clock; reset is asynchronous and active-high.
//  Reset: awready=0, wready=0, bvalid=0, bid=0, bresp=00, FSM->IDLE, error flag cleared.
//   Memory is NOT cleared. Reset mid-burst aborts the burst; no B is issued for it.
//  FSM IDLE: awready=1 (from first posedge after reset release). On awvalid&&awready capture
//   id/addr/len/size/burst, beat_cnt=0, err=0 -> DATA; awready=0 next cycle.
//  FSM DATA: wready=1. Each wvalid&&wready: if addr word in range, write lanes with wstrb=1
//   to mem[addr/(DATA_W/8)], else drop the beat and set err. Advance addr, beat_cnt++.
//   Beat with beat_cnt==awlen -> RESP. wready=0 in the following cycle.
//  FSM RESP: bvalid=1, bid=captured id, bresp=err?10:00; hold stable until bready -> IDLE.
//   B handshake and the next AW handshake can never occur in the same cycle (awready=0 in RESP).
//  Latency: first wready 1 cycle after AW handshake; bvalid 1 cycle after last W handshake.
//  Address update (bytes=1<<size): FIXED unchanged; INCR addr+bytes, 32-bit wrap-around
//   without error; WRAP: span=(awlen+1)*bytes, addr=(addr&~(span-1))|((addr+bytes)&(span-1)).
//  Set err (SLVERR) on any of the following. The burst still runs all awlen+1 beats:
//   - awburst=11 (treated as INCR)
//   - awsize > log2(DATA_W/8)
//   - WRAP with awlen not in {1,3,7,15}
//   - wid != captured awid on any beat
//   - wlast=1 on a beat other than the last, or wlast=0 on the last beat
//   - any out-of-range word index
//  awlen=0: single beat. Back-to-back bursts: new AW accepted the cycle after B handshake.
//  Simultaneous write and dbg read of the same word: dbg_data shows old data until the edge.
// TESTING
//  Single beat: awaddr=0x10,awlen=0,INCR,size=2,wdata=0xDEADBEEF,wstrb=F -> bresp=00, mem[4]=DEADBEEF.
//  INCR 4 beats from 0x0, data 1..4, bready held low 5 cycles -> bvalid,bid stable; mem[0..3]=1..4.
//  WRAP 4 beats at 0x38 (span 16) -> word writes go to 0x38,0x3C,0x30,0x34; bresp=00.
//  wstrb=4'b0101 over a word preloaded with 0xFFFFFFFF, wdata=0 -> mem word=0xFF00FF00.
//  Errors: awaddr=0x400 (out of range); early wlast on beat 1 of 4; wid mismatch -> each bresp=10.
//  Assert areset mid-burst (beat 2 of 8) -> bvalid=0; completed beats stay in mem; next AW accepted.

Source files
------------

// File: rtl/axi_wr_slave_mem.sv
// AXI3/4 write-channel slave with an internal word-addressed memory.
// Accepts one AW burst at a time, consumes FIXED/INCR/WRAP W beats with byte
// strobes, and returns a single B response (SLVERR on any protocol/range error).
// Ports:
//   clock, areset           single clock, asynchronous active-high reset
//   aw*                     write address channel (awready registered)
//   w*                      write data channel (wready registered)
//   bid/bresp/bvalid/bready write response channel (registered)
//   dbg_addr/dbg_data       combinational sideband read of memory
module axi_wr_slave_mem #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned ID_W      = 4,
  parameter int unsigned MEM_WORDS = 256
) (
  input  logic                         clock,
  input  logic                         areset,
  input  logic [ID_W-1:0]              awid,
  input  logic [ADDR_W-1:0]            awaddr,
  input  logic [7:0]                   awlen,
  input  logic [2:0]                   awsize,
  input  logic [1:0]                   awburst,
  input  logic                         awvalid,
  output logic                         awready,
  input  logic [ID_W-1:0]              wid,
  input  logic [DATA_W-1:0]            wdata,
  input  logic [DATA_W/8-1:0]          wstrb,
  input  logic                         wlast,
  input  logic                         wvalid,
  output logic                         wready,
  output logic [ID_W-1:0]              bid,
  output logic [1:0]                   bresp,
  output logic                         bvalid,
  input  logic                         bready,
  input  logic [$clog2(MEM_WORDS)-1:0] dbg_addr,
  output logic [DATA_W-1:0]            dbg_data
);

  localparam int unsigned STRB_W     = DATA_W / 8;
  localparam int unsigned IDX_W      = $clog2(MEM_WORDS);
  localparam int unsigned LANE_SHIFT = $clog2(STRB_W);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_RESP} state_t;

  state_t              state_q, state_d;
  logic [ID_W-1:0]     id_q, id_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d;
  logic [1:0]          burst_q, burst_d;
  logic [7:0]          beat_q, beat_d;
  logic                err_q, err_d;
  logic                awready_d, wready_d, bvalid_d;
  logic [ID_W-1:0]     bid_d;
  logic [1:0]          bresp_d;

  logic [DATA_W-1:0]   mem [MEM_WORDS];

  logic                aw_hs, w_hs, last_beat, in_range, aw_err;
  logic [ADDR_W-1:0]   word_full, next_addr, bytes, span;
  logic [IDX_W-1:0]    word_idx;

  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign last_beat = (beat_q == len_q);
  assign word_full = addr_q >> LANE_SHIFT;
  assign in_range  = (word_full < ADDR_W'(MEM_WORDS));
  assign word_idx  = word_full[IDX_W-1:0];
  assign dbg_data  = mem[dbg_addr];

  // Burst attributes that are illegal regardless of the data beats
  assign aw_err = (awburst == 2'b11) ||
                  (awsize > 3'(LANE_SHIFT)) ||
                  ((awburst == 2'b10) && !(awlen inside {8'd1, 8'd3, 8'd7, 8'd15}));

  // Address of the next beat; reserved burst type behaves as INCR
  always_comb begin
    bytes = ADDR_W'(1) << size_q;
    span  = (ADDR_W'(len_q) + ADDR_W'(1)) << size_q;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      2'b10:   next_addr = (addr_q & ~(span - ADDR_W'(1))) |
                           ((addr_q + bytes) & (span - ADDR_W'(1)));
      default: next_addr = addr_q + bytes;
    endcase
  end

  // Next-state and next-output logic
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    addr_d  = addr_q;
    len_d   = len_q;
    size_d  = size_q;
    burst_d = burst_q;
    beat_d  = beat_q;
    err_d   = err_q;
    bid_d   = bid;
    bresp_d = bresp;
    case (state_q)
      S_IDLE: begin
        if (aw_hs) begin
          id_d    = awid;
          addr_d  = awaddr;
          len_d   = awlen;
          size_d  = awsize;
          burst_d = awburst;
          beat_d  = 8'd0;
          err_d   = aw_err;
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        if (w_hs) begin
          err_d  = err_q || !in_range || (wid != id_q) || (wlast != last_beat);
          addr_d = next_addr;
          beat_d = beat_q + 8'd1;
          if (last_beat) begin
            state_d = S_RESP;
            bid_d   = id_q;
            bresp_d = err_d ? 2'b10 : 2'b00;
          end
        end
      end
      S_RESP: begin
        if (bvalid && bready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    awready_d = (state_d == S_IDLE);
    wready_d  = (state_d == S_DATA);
    bvalid_d  = (state_d == S_RESP);
  end

  // State and registered outputs
  always_ff @(posedge clock or posedge areset) begin
    if (areset) begin
      state_q <= S_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      err_q   <= 1'b0;
      awready <= 1'b0;
      wready  <= 1'b0;
      bvalid  <= 1'b0;
      bid     <= '0;
      bresp   <= 2'b00;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      burst_q <= burst_d;
      beat_q  <= beat_d;
      err_q   <= err_d;
      awready <= awready_d;
      wready  <= wready_d;
      bvalid  <= bvalid_d;
      bid     <= bid_d;
      bresp   <= bresp_d;
    end
  end

  // Byte-lane memory write; out-of-range beats are dropped, memory survives reset
  always_ff @(posedge clock) begin
    if (w_hs && in_range) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) mem[word_idx][b*8 +: 8] <= wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_wr_slave_mem.sv
// Directed bench for axi_wr_slave_mem: expected B responses are queued when a
// burst is issued and compared when B arrives; a byte-level memory model is
// compared through the debug read port.
module tb_axi_wr_slave_mem;

  logic        clock = 1'b0;
  logic        areset;
  logic [3:0]  awid, wid, bid;
  logic [31:0] awaddr, wdata, dbg_data;
  logic [7:0]  awlen, dbg_addr;
  logic [2:0]  awsize;
  logic [1:0]  awburst, bresp;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  typedef struct packed {
    logic [3:0] id;
    logic [1:0] resp;
  } b_exp_t;

  b_exp_t      sb[$];
  logic [31:0] tb_mem [256];
  bit          tb_val [256];
  int          checks = 0;
  int          failures = 0;

  always #5 clock = ~clock;

  axi_wr_slave_mem dut (
    .clock(clock), .areset(areset),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize),
    .awburst(awburst), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast),
    .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] tb_next(input logic [31:0] a, input logic [7:0] len,
                                          input logic [2:0] size, input logic [1:0] bt);
    logic [31:0] nb, sp, base;
    nb = 32'd1 << size;
    if (bt == 2'b00) return a;
    if (bt == 2'b10) begin
      sp   = (32'(len) + 32'd1) * nb;
      base = a - (a % sp);
      return base + ((a - base + nb) % sp);
    end
    return a + nb;
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int idx;
    if ((a >> 2) < 32'd256) begin
      idx = int'(a >> 2);
      for (int b = 0; b < 4; b++) if (s[b]) tb_mem[idx][b*8 +: 8] = d[b*8 +: 8];
      if (s == 4'hF) tb_val[idx] = 1'b1;
    end
  endtask

  task automatic check_mem(input int idx, input logic [31:0] exp);
    dbg_addr = 8'(idx);
    #1;
    chk($sformatf("mem[%0d]", idx), dbg_data, exp);
  endtask

  task automatic send_aw(input logic [3:0] id, input logic [31:0] a, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] bt);
    int n = 0;
    awid = id; awaddr = a; awlen = len; awsize = size; awburst = bt; awvalid = 1'b1;
    while (!awready && n < 50) begin step(); n++; end
    chk("awready_wait", awready, 1'b1);
    step();
    awvalid = 1'b0;
    chk("aw_to_wready", wready, 1'b1);
    chk("awready_drop", awready, 1'b0);
  endtask

  task automatic send_beat(input logic [3:0] id, input logic [31:0] d, input logic [3:0] s,
                           input logic last);
    int n = 0;
    wid = id; wdata = d; wstrb = s; wlast = last; wvalid = 1'b1;
    while (!wready && n < 50) begin step(); n++; end
    chk("wready_wait", wready, 1'b1);
    step();
    wvalid = 1'b0;
  endtask

  task automatic get_b(input int hold);
    b_exp_t e;
    int n = 0;
    while (!bvalid && n < 50) begin step(); n++; end
    chk("bvalid_wait", bvalid, 1'b1);
    chk("sb_nonempty", sb.size() > 0, 1'b1);
    e = (sb.size() > 0) ? sb.pop_front() : '0;
    bready = 1'b0;
    for (int i = 0; i < hold; i++) begin
      step();
      chk("bvalid_hold", bvalid, 1'b1);
      chk("bid_hold", bid, e.id);
      chk("bresp_hold", bresp, e.resp);
    end
    bready = 1'b1;
    chk("bid", bid, e.id);
    chk("bresp", bresp, e.resp);
    step();
    bready = 1'b0;
    chk("bvalid_clear", bvalid, 1'b0);
    chk("awready_after_b", awready, 1'b1);
  endtask

  task automatic burst(input logic [3:0] id, input logic [31:0] a0, input logic [7:0] len,
                       input logic [2:0] size, input logic [1:0] bt, input logic [31:0] dbase,
                       input logic [3:0] s, input int bad_last, input int bad_wid,
                       input int hold, input logic [1:0] exp_resp);
    logic [31:0] a;
    sb.push_back('{id: id, resp: exp_resp});
    send_aw(id, a0, len, size, bt);
    a = a0;
    for (int i = 0; i <= int'(len); i++) begin
      send_beat((i == bad_wid) ? (id ^ 4'h1) : id, dbase + 32'(i), s,
                (i == int'(len)) ^ (i == bad_last));
      model_write(a, dbase + 32'(i), s);
      a = tb_next(a, len, size, bt);
    end
    chk("last_to_bvalid", bvalid, 1'b1);
    get_b(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    areset = 1'b1;
    awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
    wid = '0; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;
    bready = 1'b0; dbg_addr = '0;
    for (int i = 0; i < 256; i++) begin tb_mem[i] = '0; tb_val[i] = 1'b0; end
    step(); step();
    chk("rst_awready", awready, 1'b0);
    chk("rst_wready", wready, 1'b0);
    chk("rst_bvalid", bvalid, 1'b0);
    chk("rst_bid", bid, 4'h0);
    chk("rst_bresp", bresp, 2'b00);
    areset = 1'b0;
    step();
    chk("idle_awready", awready, 1'b1);

    // Single beat
    burst(4'h3, 32'h10, 8'd0, 3'd2, 2'b01, 32'hDEADBEEF, 4'hF, -1, -1, 0, 2'b00);
    check_mem(4, 32'hDEADBEEF);

    // INCR 4 beats, response stalled 5 cycles
    burst(4'h6, 32'h0, 8'd3, 3'd2, 2'b01, 32'd1, 4'hF, -1, -1, 5, 2'b00);
    check_mem(0, 32'd1); check_mem(1, 32'd2); check_mem(2, 32'd3); check_mem(3, 32'd4);

    // WRAP 4 beats starting at 0x38: 0x38,0x3C,0x30,0x34
    burst(4'h1, 32'h38, 8'd3, 3'd2, 2'b10, 32'hA0, 4'hF, -1, -1, 0, 2'b00);
    check_mem(14, 32'hA0); check_mem(15, 32'hA1); check_mem(12, 32'hA2); check_mem(13, 32'hA3);

    // Partial strobe over a preloaded word
    burst(4'h2, 32'h40, 8'd0, 3'd2, 2'b01, 32'hFFFFFFFF, 4'hF, -1, -1, 0, 2'b00);
    burst(4'h2, 32'h40, 8'd0, 3'd2, 2'b01, 32'h0, 4'b0101, -1, -1, 0, 2'b00);
    check_mem(16, 32'hFF00FF00);

    // FIXED: every beat lands on the same word, last one wins
    burst(4'h4, 32'h50, 8'd2, 3'd2, 2'b00, 32'h500, 4'hF, -1, -1, 0, 2'b00);
    check_mem(20, 32'h502);

    // Error cases
    burst(4'h7, 32'h400, 8'd0, 3'd2, 2'b01, 32'h1234, 4'hF, -1, -1, 0, 2'b10);
    burst(4'h8, 32'h100, 8'd3, 3'd2, 2'b01, 32'hB0, 4'hF, 1, -1, 0, 2'b10);
    burst(4'h9, 32'h200, 8'd1, 3'd2, 2'b01, 32'hC0, 4'hF, -1, 1, 0, 2'b10);
    burst(4'hA, 32'h280, 8'd1, 3'd2, 2'b11, 32'hD0, 4'hF, -1, -1, 0, 2'b10);
    burst(4'hB, 32'h300, 8'd1, 3'd3, 2'b01, 32'hE0, 4'hF, -1, -1, 0, 2'b10);
    check_mem(64, 32'hB0); check_mem(67, 32'hB3);
    check_mem(194, 32'hE1);

    // Reset in the middle of an 8-beat burst, during beat 2
    send_aw(4'h5, 32'h80, 8'd7, 3'd2, 2'b01);
    send_beat(4'h5, 32'hF0, 4'hF, 1'b0); model_write(32'h80, 32'hF0, 4'hF);
    send_beat(4'h5, 32'hF1, 4'hF, 1'b0); model_write(32'h84, 32'hF1, 4'hF);
    wid = 4'h5; wdata = 32'hF2; wstrb = 4'hF; wlast = 1'b0; wvalid = 1'b1;
    areset = 1'b1;
    #1;
    chk("abort_wready", wready, 1'b0);
    chk("abort_bvalid", bvalid, 1'b0);
    step(); step();
    wvalid = 1'b0;
    areset = 1'b0;
    chk("abort_awready_rst", awready, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("abort_no_b", bvalid, 1'b0);
    end
    chk("abort_awready", awready, 1'b1);
    check_mem(32, 32'hF0); check_mem(33, 32'hF1);
    burst(4'hC, 32'h90, 8'd1, 3'd2, 2'b01, 32'h90, 4'hF, -1, -1, 0, 2'b00);
    check_mem(36, 32'h90); check_mem(37, 32'h91);

    // Whole-memory sweep against the model
    for (int i = 0; i < 256; i++) if (tb_val[i]) check_mem(i, tb_mem[i]);
    chk("sb_empty", sb.size() == 0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
